// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline-register defaults and the MEM/WB payload type.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int c_xlen_default    = 64;
    localparam int c_raddr_w_default = 5;

    typedef struct packed {
        logic                         mem_to_reg;
        logic                         reg_write;
        logic [c_xlen_default-1:0]    read_data;
        logic [c_xlen_default-1:0]    alu_result;
        logic [c_raddr_w_default-1:0] rd;
    } wb_payload_t;

    // Flattened payload width for parametrised stages that cannot use the fixed struct.
    function automatic int wb_payload_width(input int xlen, input int raddr_w);
        return 2 + 2 * xlen + raddr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_buf
// Description : Two-slot valid/ready skid buffer with flush; in_ready is a pure register.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_m_valid;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_m_data;
    logic [WIDTH-1:0] r_s_data;
    logic             w_in_fire;
    logic             w_out_fire;

    assign in_ready   = ~r_s_valid;
    assign out_valid  = r_m_valid;
    assign out_data   = r_m_data;
    assign w_in_fire  = in_valid & ~r_s_valid;
    assign w_out_fire = r_m_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_s_valid <= 1'b0;
        end else if (!r_m_valid || w_out_fire) begin
            // Skid entry is older than anything upstream, so it drains first.
            if (r_s_valid) begin
                r_m_data  <= r_s_data;
                r_m_valid <= 1'b1;
                r_s_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_m_data  <= in_data;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_s_data  <= in_data;
            r_s_valid <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_skid_stage
// Description : MEM/WB stage with skid buffer, x0 write suppression, writeback
//               mux and optional perf counters (enabled by MEM_WB_PERF_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_skid_stage
    import pipe_pkg::*;
#(
    parameter int XLEN    = c_xlen_default,
    parameter int RADDR_W = c_raddr_w_default,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mem_to_reg,
    input  logic               in_reg_write,
    input  logic [XLEN-1:0]    in_read_data,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [RADDR_W-1:0] in_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mem_to_reg,
    output logic               out_reg_write,
    output logic [XLEN-1:0]    out_read_data,
    output logic [XLEN-1:0]    out_alu_result,
    output logic [RADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]    out_wb_data
`ifdef MEM_WB_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
`endif
);

    localparam int c_payload_w = wb_payload_width(XLEN, RADDR_W);

    logic                   w_in_reg_write;
    logic                   w_m_reg_write;
    logic [c_payload_w-1:0] w_in_payload;
    logic [c_payload_w-1:0] w_out_payload;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Writes to x0 are dropped at capture so the regfile never sees them.
    assign w_in_reg_write = in_reg_write & (in_rd != '0);
    assign w_in_payload   = {in_mem_to_reg, w_in_reg_write, in_read_data, in_alu_result, in_rd};

    pipe_skid_buf #(
        .WIDTH (c_payload_w)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_payload)
    );

    assign {out_mem_to_reg, w_m_reg_write, out_read_data, out_alu_result, out_rd} = w_out_payload;
    assign out_reg_write = out_valid & w_m_reg_write;
    assign out_wb_data   = out_mem_to_reg ? out_read_data : out_alu_result;

`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!out_valid && !(&r_bubble_cnt)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_skid_stage
// Description : Self-checking bench for mem_wb_skid_stage (MEM_WB_PERF_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_skid_stage;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_mem_to_reg = 1'b0;
    logic               in_reg_write = 1'b0;
    logic [XLEN-1:0]    in_read_data = '0;
    logic [XLEN-1:0]    in_alu_result = '0;
    logic [RADDR_W-1:0] in_rd = '0;
    logic               out_ready = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               out_mem_to_reg;
    logic               out_reg_write;
    logic [XLEN-1:0]    out_read_data;
    logic [XLEN-1:0]    out_alu_result;
    logic [RADDR_W-1:0] out_rd;
    logic [XLEN-1:0]    out_wb_data;
`ifdef MEM_WB_PERF_EN
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;
`endif

    mem_wb_skid_stage #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mem_to_reg  (in_mem_to_reg),
        .in_reg_write   (in_reg_write),
        .in_read_data   (in_read_data),
        .in_alu_result  (in_alu_result),
        .in_rd          (in_rd),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_mem_to_reg (out_mem_to_reg),
        .out_reg_write  (out_reg_write),
        .out_read_data  (out_read_data),
        .out_alu_result (out_alu_result),
        .out_rd         (out_rd),
        .out_wb_data    (out_wb_data)
`ifdef MEM_WB_PERF_EN
        ,
        .stall_cnt      (stall_cnt),
        .bubble_cnt     (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an ordered queue of at most two accepted entries; head is what WB sees.
    typedef struct packed {
        logic               mtr;
        logic               rw;
        logic [XLEN-1:0]    rdat;
        logic [XLEN-1:0]    alu;
        logic [RADDR_W-1:0] rd;
    } ent_t;

    ent_t q[$];
    ent_t held;
    ent_t m_new;
    ent_t m_show;
    int   m_stall;
    int   m_bubble;
    bit   m_in_fire;
    bit   m_out_fire;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            held     = '0;
            m_stall  = 0;
            m_bubble = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < CNT_MAX) m_stall++;
            if (q.size() == 0 && m_bubble < CNT_MAX) m_bubble++;
            if (q.size() > 0) held = q[0];
            if (flush) begin
                q.delete();
            end else begin
                m_in_fire  = in_valid && (q.size() < 2);
                m_out_fire = (q.size() > 0) && out_ready;
                if (m_out_fire) void'(q.pop_front());
                if (m_in_fire) begin
                    m_new = {in_mem_to_reg, in_reg_write, in_read_data, in_alu_result, in_rd};
                    q.push_back(m_new);
                end
            end
        end
    end

    always @(negedge clk) begin
        m_show = (q.size() > 0) ? q[0] : held;
        check("cmp_out_valid", out_valid, q.size() > 0);
        check("cmp_in_ready", in_ready, q.size() < 2);
        check("cmp_mem_to_reg", out_mem_to_reg, m_show.mtr);
        check("cmp_read_data", out_read_data, m_show.rdat);
        check("cmp_alu_result", out_alu_result, m_show.alu);
        check("cmp_rd", out_rd, m_show.rd);
        check("cmp_reg_write", out_reg_write, (q.size() > 0) && m_show.rw && (m_show.rd != 0));
        check("cmp_wb_data", out_wb_data, m_show.mtr ? m_show.rdat : m_show.alu);
`ifdef MEM_WB_PERF_EN
        check("cmp_stall_cnt", stall_cnt, m_stall);
        check("cmp_bubble_cnt", bubble_cnt, m_bubble);
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mtr, input logic rw, input logic [XLEN-1:0] rdat,
                        input logic [XLEN-1:0] alu, input logic [RADDR_W-1:0] rd);
        in_valid      = 1'b1;
        in_mem_to_reg = mtr;
        in_reg_write  = rw;
        in_read_data  = rdat;
        in_alu_result = alu;
        in_rd         = rd;
        for (int k = 0; k < 50 && !in_ready; k++) step();
        check("send_ready", in_ready, 1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wb_data", out_wb_data, 0);
        check("rst_reg_write", out_reg_write, 0);

        // Unstalled stream: one-cycle latency, full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 1'b1, 64'hFFFF, 64'h10 + 64'(i), 5'd5);
            check("t1_valid", out_valid, 1);
            check("t1_wb_data", out_wb_data, 64'h10 + 64'(i));
            check("t1_reg_write", out_reg_write, 1);
            check("t1_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("t1_drained", out_valid, 0);

        // Backpressure fills both slots; third entry waits upstream.
        out_ready = 1'b0;
        send(1'b0, 1'b1, 64'h0, 64'hA0, 5'd1);
        send(1'b0, 1'b1, 64'h0, 64'hB0, 5'd2);
        check("t2_in_ready_full", in_ready, 0);
        check("t2_head", out_alu_result, 64'hA0);
        in_valid      = 1'b1;
        in_alu_result = 64'hC0;
        in_rd         = 5'd3;
        step();
        check("t2_c_held", in_ready, 0);
        check("t2_head_kept", out_alu_result, 64'hA0);
        out_ready = 1'b1;
        send(1'b0, 1'b1, 64'h0, 64'hC0, 5'd3);
        in_valid = 1'b0;
        check("t2_c_last", out_alu_result, 64'hC0);
        repeat (2) step();

        // x0 destination: write enable dropped, payload intact.
        send(1'b0, 1'b1, 64'h1234_5678, 64'h33, 5'd0);
        in_valid = 1'b0;
        check("t3_valid", out_valid, 1);
        check("t3_reg_write", out_reg_write, 0);
        check("t3_alu", out_alu_result, 64'h33);
        check("t3_read_data", out_read_data, 64'h1234_5678);
        step();

        // Flush with both slots full and a new offer.
        out_ready = 1'b0;
        send(1'b0, 1'b1, 64'h0, 64'h40, 5'd3);
        send(1'b0, 1'b1, 64'h0, 64'h41, 5'd4);
        in_valid      = 1'b1;
        in_alu_result = 64'h42;
        in_rd         = 5'd6;
        flush         = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_valid", out_valid, 0);
        check("t4_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) step();
        check("t4_no_reappear", out_valid, 0);

        // Memory-data writeback, then asynchronous reset mid-stall.
        out_ready = 1'b0;
        send(1'b1, 1'b1, 64'hDEAD_BEEF, 64'h4, 5'd7);
        in_valid = 1'b0;
        step();
        check("t5_wb_data", out_wb_data, 64'hDEAD_BEEF);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_wb_data", out_wb_data, 0);
        check("t5_rst_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        step();

`ifdef MEM_WB_PERF_EN
        out_ready = 1'b0;
        send(1'b0, 1'b1, 64'h0, 64'h55, 5'd8);
        in_valid = 1'b0;
        repeat (20) step();
        check("t6_stall_sat", stall_cnt, 15);
        out_ready = 1'b1;
        repeat (3) step();
        check("t6_stall_hold", stall_cnt, 15);
`endif

        out_ready = 1'b1;
        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
